// File: rtl/mandel_sched.sv
// Mandelbrot frame scheduler: walks the raster, hands coordinates round-robin to the
// iteration engines and funnels their results onto the frame-buffer write port. Option: FB_CLEAR_EN.

module mandel_sched_lane #(
  parameter int IDX   = 0,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int DW    = 7,
  parameter int N     = 2
) (
  input  logic [N*10-1:0] res_x,
  input  logic [N*9-1:0]  res_y,
  input  logic [N*DW-1:0] res_iter,
  output logic [9:0]      x,
  output logic [8:0]      y,
  output logic [DW-1:0]   iter,
  output logic            ok
);
  assign x    = res_x[10*IDX +: 10];
  assign y    = res_y[9*IDX +: 9];
  assign iter = res_iter[DW*IDX +: DW];
  assign ok   = (int'(x) < H_RES) && (int'(y) < V_RES);
endmodule

module mandel_sched #(
  parameter int NUM_ENG = 2,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int DW      = 7
) (
  input  logic                 CLK_100MHz,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [NUM_ENG-1:0]   job_ready,
  output logic [NUM_ENG-1:0]   job_valid,
  output logic [9:0]           job_x,
  output logic [8:0]           job_y,
  input  logic [NUM_ENG-1:0]   res_valid,
  output logic [NUM_ENG-1:0]   res_ready,
  input  logic [NUM_ENG*10-1:0] res_x,
  input  logic [NUM_ENG*9-1:0]  res_y,
  input  logic [NUM_ENG*DW-1:0] res_iter,
  output logic                 wea,
  output logic [18:0]          addr_w,
  output logic [DW-1:0]        dina
);
  localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [18:0] LAST = 19'(H_RES*V_RES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic [9:0]    x, x_nxt;
  logic [8:0]    y, y_nxt;
  logic [18:0]   issued, written;
  logic          all_written;
  logic [PW-1:0] disp_ptr, col_ptr;
`ifdef FB_CLEAR_EN
  logic          clr_done;
`endif

  logic [NUM_ENG-1:0][9:0]    lx;
  logic [NUM_ENG-1:0][8:0]    ly;
  logic [NUM_ENG-1:0][DW-1:0] li;
  logic [NUM_ENG-1:0]         lok;

  for (genvar g = 0; g < NUM_ENG; g++) begin : g_lane
    mandel_sched_lane #(.IDX(g), .H_RES(H_RES), .V_RES(V_RES), .DW(DW), .N(NUM_ENG)) u_lane (
      .res_x(res_x), .res_y(res_y), .res_iter(res_iter),
      .x(lx[g]), .y(ly[g]), .iter(li[g]), .ok(lok[g])
    );
  end

  // First requester at or after ptr; MSB flags that anyone was found.
  function automatic logic [PW:0] rr_pick(input logic [NUM_ENG-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      idx = (int'(ptr) + k) % NUM_ENG;
      if (!r[PW] && req[idx]) r = {1'b1, PW'(idx)};
    end
    return r;
  endfunction

  logic          d_any, c_any, d_go, c_go;
  logic [PW-1:0] d_pick, c_pick, d_nxt, c_nxt;

  always_comb begin
    {d_any, d_pick} = rr_pick(job_ready, disp_ptr);
    {c_any, c_pick} = rr_pick(res_valid, col_ptr);
    d_go  = (state == S_RUN) && d_any;
    c_go  = ((state == S_RUN) || (state == S_DRAIN)) && c_any;
    d_nxt = PW'((int'(d_pick) + 1) % NUM_ENG);
    c_nxt = PW'((int'(c_pick) + 1) % NUM_ENG);
    job_valid = d_go ? (NUM_ENG'(1) << d_pick) : '0;
    res_ready = c_go ? (NUM_ENG'(1) << c_pick) : '0;
    job_x = x;
    job_y = y;
    x_nxt = (x == 10'(H_RES - 1)) ? 10'd0 : x + 10'd1;
    y_nxt = (x == 10'(H_RES - 1)) ? y + 9'd1 : y;
  end

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wea         <= 1'b0;
      addr_w      <= '0;
      dina        <= '0;
      x           <= '0;
      y           <= '0;
      issued      <= '0;
      written     <= '0;
      all_written <= 1'b0;
      disp_ptr    <= '0;
      col_ptr     <= '0;
`ifdef FB_CLEAR_EN
      clr_done    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      wea  <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          busy        <= 1'b1;
          err         <= 1'b0;
          x           <= '0;
          y           <= '0;
          issued      <= '0;
          written     <= '0;
          all_written <= 1'b0;
`ifdef FB_CLEAR_EN
          clr_done    <= 1'b0;
          state       <= S_CLEAR;
`else
          state       <= S_RUN;
`endif
        end
`ifdef FB_CLEAR_EN
        // One spare cycle after the last clear write keeps the write port quiet into RUN.
        S_CLEAR: if (!clr_done) begin
          wea    <= 1'b1;
          addr_w <= {y, x};
          dina   <= '0;
          x      <= x_nxt;
          y      <= y_nxt;
          issued <= issued + 19'd1;
          if (issued == LAST) clr_done <= 1'b1;
        end else begin
          x      <= '0;
          y      <= '0;
          issued <= '0;
          state  <= S_RUN;
        end
`endif
        S_RUN: if (d_go) begin
          x        <= x_nxt;
          y        <= y_nxt;
          issued   <= issued + 19'd1;
          disp_ptr <= d_nxt;
          if (issued == LAST) state <= S_DRAIN;
        end
        S_DRAIN: if (all_written) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Bad coordinates are still consumed and counted so the frame can finish.
      if (c_go) begin
        col_ptr <= c_nxt;
        written <= written + 19'd1;
        if (written == LAST) all_written <= 1'b1;
        if (lok[c_pick]) begin
          wea    <= 1'b1;
          addr_w <= {ly[c_pick], lx[c_pick]};
          dina   <= li[c_pick];
        end else begin
          err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mandel_sched.sv
// Directed bench for mandel_sched on a 4x2 raster with two behavioural engines.
module tb_mandel_sched;
  localparam int NE = 2, HR = 4, VR = 2, DW = 7;
`ifdef FB_CLEAR_EN
  localparam int NCLR = HR*VR;
`else
  localparam int NCLR = 0;
`endif

  logic clk = 0, reset = 1, start = 0;
  logic busy, done, err, wea;
  logic [NE-1:0] job_ready = '0, job_valid, res_valid, res_ready;
  logic [9:0] job_x;
  logic [8:0] job_y;
  logic [NE*10-1:0] res_x;
  logic [NE*9-1:0]  res_y;
  logic [NE*DW-1:0] res_iter;
  logic [18:0] addr_w;
  logic [DW-1:0] dina;

  always #5 clk = ~clk;

  mandel_sched #(.NUM_ENG(NE), .H_RES(HR), .V_RES(VR), .DW(DW)) dut (
    .CLK_100MHz(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .job_ready(job_ready), .job_valid(job_valid), .job_x(job_x), .job_y(job_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_iter(res_iter), .wea(wea), .addr_w(addr_w), .dina(dina)
  );

  // Engine model: results appear 3 cycles after acceptance, iter = x+y, in order per engine.
  typedef struct {int eng; int x; int y; int cyc;} job_t;
  typedef struct {int addr; int dat; int cyc;} wr_t;
  typedef struct {int x; int y; int due;} pend_t;
  job_t jlog[$];
  wr_t  wlog[$];
  pend_t q0[$], q1[$];
  int cyc = 0, done_cyc = -1;
  logic jv0_seen = 0, manual = 0;
  logic [1:0] e_valid = 0, mv = 0;
  logic [19:0] e_x = 0, m_x = 0;
  logic [17:0] e_y = 0, m_y = 0;
  logic [13:0] e_it = 0, m_it = 0;

  assign res_valid = manual ? mv : e_valid;
  assign res_x     = manual ? m_x : e_x;
  assign res_y     = manual ? m_y : e_y;
  assign res_iter  = manual ? m_it : e_it;

  initial begin : model
    logic [1:0] jhs, rhs;
    int jx, jy;
    forever begin
      @(negedge clk); #4;
      jhs = job_valid & job_ready; rhs = res_valid & res_ready;
      jx = int'(job_x); jy = int'(job_y);
      if (job_valid[0]) jv0_seen = 1;
      if (wea) wlog.push_back('{int'(addr_w), int'(dina), cyc});
      if (done) done_cyc = cyc;
      @(posedge clk); cyc++;
      if (reset) begin q0.delete(); q1.delete(); end
      else begin
        if (!manual && rhs[0]) void'(q0.pop_front());
        if (!manual && rhs[1]) void'(q1.pop_front());
        if (jhs != 0) begin
          jlog.push_back('{jhs[1] ? 1 : 0, jx, jy, cyc});
          if (!manual) begin
            if (jhs[1]) q1.push_back('{jx, jy, cyc + 3});
            else        q0.push_back('{jx, jy, cyc + 3});
          end
        end
      end
      #1;
      e_valid = 0;
      if (q0.size() > 0 && q0[0].due <= cyc) begin
        e_valid[0] = 1; e_x[9:0] = 10'(q0[0].x); e_y[8:0] = 9'(q0[0].y); e_it[6:0] = 7'(q0[0].x + q0[0].y);
      end
      if (q1.size() > 0 && q1[0].due <= cyc) begin
        e_valid[1] = 1; e_x[19:10] = 10'(q1[0].x); e_y[17:9] = 9'(q1[0].y); e_it[13:7] = 7'(q1[0].x + q1[0].y);
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick; @(negedge clk); #1; endtask

  task automatic pulse_start; tick; start = 1; tick; start = 0; endtask

  task automatic do_reset; reset = 1; tick; tick; reset = 0; tick; endtask

  task automatic wait_done(input string tag);
    logic ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick;
      if (done) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
  endtask

  // Full 4x2 frame in raster order with iter = x+y, done one cycle after the last write.
  task automatic chk_frame(input string tag);
    chk({tag, "_nwr"}, wlog.size(), NCLR + HR*VR);
    if (wlog.size() == NCLR + HR*VR) begin
      for (int i = 0; i < HR*VR; i++) begin
        chk({tag, "_addr"}, wlog[NCLR+i].addr, (i / HR) * 1024 + (i % HR));
        chk({tag, "_data"}, wlog[NCLR+i].dat, (i / HR) + (i % HR));
      end
      chk({tag, "_done_lat"}, done_cyc, wlog[NCLR+HR*VR-1].cyc + 1);
    end
  endtask

  task automatic chk_jobs(input string tag, input bit alternate);
    chk({tag, "_njob"}, jlog.size(), HR*VR);
    if (jlog.size() == HR*VR)
      for (int i = 0; i < HR*VR; i++) begin
        chk({tag, "_eng"}, jlog[i].eng, alternate ? i % 2 : 1);
        chk({tag, "_xy"}, {jlog[i].y[15:0], jlog[i].x[15:0]}, {16'(i / HR), 16'(i % HR)});
      end
  endtask

  task automatic clr_logs; jlog.delete(); wlog.delete(); done_cyc = -1; jv0_seen = 0; endtask

  initial begin
    // reset state
    tick; tick;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_wea", wea, 0); chk("rst_addr", addr_w, 0); chk("rst_dina", dina, 0);
    job_ready = 2'b11; #1;
    chk("rst_jv", job_valid, 0);
    reset = 0; tick;
    chk("idle_jv", job_valid, 0);

    // 1: both engines always ready
    clr_logs; pulse_start; #1;
    chk("t1_busy", busy, 1);
    wait_done("t1_done");
    tick;
    chk("t1_idle", busy, 0);
    chk_jobs("t1", 1); chk_frame("t1"); chk("t1_err", err, 0);

    // 2: engine 0 never ready
    job_ready = 2'b10; clr_logs; pulse_start;
    wait_done("t2_done");
    tick;
    chk_jobs("t2", 0); chk_frame("t2"); chk("t2_jv0", jv0_seen, 0);

    // 3: simultaneous results from a known collect pointer
    do_reset; job_ready = 2'b00; manual = 1; clr_logs; pulse_start;
    repeat (NCLR > 0 ? NCLR + 1 : 0) tick;
    mv = 2'b11; m_x = {10'd2, 10'd1}; m_y = {9'd1, 9'd0}; m_it = {7'd9, 7'd5}; #1;
    chk("t3_rr0", res_ready, 2'b01);
    tick; mv = 2'b10; #1;
    chk("t3_rr1", res_ready, 2'b10);
    chk("t3_wea0", wea, 1); chk("t3_addr0", addr_w, 19'h00001); chk("t3_dina0", dina, 5);
    tick; mv = 2'b00; #1;
    chk("t3_wea1", wea, 1); chk("t3_addr1", addr_w, 19'h00402); chk("t3_dina1", dina, 9);
    chk("t3_rr_idle", res_ready, 0);
    tick;
    chk("t3_wea_off", wea, 0); chk("t3_addr_hold", addr_w, 19'h00402);

    // 4: out-of-range x is consumed, not written, flags err
    mv = 2'b01; m_x[9:0] = 10'd5; m_y[8:0] = 9'd0; m_it[6:0] = 7'd3; #1;
    chk("t4_rr", res_ready, 2'b01);
    tick; mv = 2'b00; #1;
    chk("t4_wea", wea, 0); chk("t4_err", err, 1); chk("t4_addr_hold", addr_w, 19'h00402);
    job_ready = 2'b11; mv = 2'b01; m_x[9:0] = 10'd0; m_it[6:0] = 7'd1;
    repeat (5) tick;
    mv = 2'b00;
    wait_done("t4_done");
    chk("t4_err_at_done", err, 1);
    manual = 0; clr_logs; pulse_start; #1;
    chk("t4_err_clr", err, 0); chk("t4_busy", busy, 1);
    wait_done("t4_done2");
    tick;
    chk_frame("t4b");

    // 5: reset mid-frame, then a clean restart
    clr_logs; pulse_start;
    begin
      logic ok = 0;
      for (int i = 0; i < 50; i++) begin
        tick;
        if (jlog.size() >= 3) begin ok = 1; break; end
      end
      chk("t5_three_jobs", ok, 1);
    end
    reset = 1; #1;
    chk("t5_busy", busy, 0); chk("t5_wea", wea, 0); chk("t5_jv", job_valid, 0); chk("t5_rr", res_ready, 0);
    tick; tick; reset = 0; tick;
    chk("t5_idle_jv", job_valid, 0);
    clr_logs; pulse_start;
    wait_done("t5_done");
    tick;
    chk_jobs("t5", 1); chk_frame("t5");

`ifdef FB_CLEAR_EN
    // 6: clear pass precedes the first dispatch
    clr_logs; pulse_start;
    wait_done("t6_done");
    tick;
    chk_frame("t6");
    if (wlog.size() >= NCLR && jlog.size() > 0)
      for (int i = 0; i < NCLR; i++) begin
        chk("t6_clr_addr", wlog[i].addr, (i / HR) * 1024 + (i % HR));
        chk("t6_clr_data", wlog[i].dat, 0);
        chk("t6_clr_first", wlog[i].cyc < jlog[0].cyc, 1);
      end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
